// File: rtl/clk_div_pkg.sv
// Shared defaults and a divisor helper for the clock divider bank.
// Pure constants and a function: no latency, no flow control.
package clk_div_pkg;

    localparam int          CNT_W_DEF   = 32;
    localparam int unsigned DEF_DIV_DEF = 104167;
    localparam logic [63:0] SYS_CLK_HZ  = 64'd100_000_000;

    // Half-period divisor for a square output at hz, rounded to nearest.
    function automatic logic [31:0] div_for_hz(input logic [31:0] hz);
        logic [63:0] den;
        den = {31'd0, hz, 1'b0};
        if (den == 64'd0) begin
            return 32'd0;
        end
        return 32'((SYS_CLK_HZ + den / 64'd2) / den);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active divisor, counter, square and tick outputs.
// Outputs registered; a new divisor takes effect at the next wrap, no backpressure.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shd;
    logic             sq;
    logic             tk;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            div_act <= RST_DIV;
            div_shd <= RST_DIV;
            sq      <= 1'b0;
            tk      <= 1'b0;
        end else begin
            if (wr) begin
                div_shd <= wr_div;
            end
            // div_act loads the pre-edge shadow, so a same-edge write waits a full period.
            if (sync || (div_act == '0)) begin
                cnt     <= '0;
                tk      <= 1'b0;
                sq      <= 1'b0;
                div_act <= div_shd;
            end else if (cnt == div_act - ONE) begin
                cnt     <= '0;
                tk      <= 1'b1;
                sq      <= ~sq;
                div_act <= div_shd;
            end else begin
                cnt <= cnt + ONE;
                tk  <= 1'b0;
            end
        end
    end

    assign clk_out = sq;
    assign tick    = tk;
    assign pend    = (div_shd != div_act);

endmodule

// File: rtl/clk_div_bank.sv
// NUM_CH programmable clock dividers with write decode; CLKDIV_SYNC_EN adds sync_in phase alignment.
// Outputs registered per channel; writes always accepted, applied at each channel's next wrap.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = DEF_DIV_DEF,
    parameter int          CH_W    = 4
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_in,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    logic sync;
    logic wr_ok;

`ifdef CLKDIV_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    // Out-of-range channel numbers are dropped here so no channel sees them.
    assign wr_ok = wr_en && (int'(wr_ch) < NUM_CH);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_in  (clk_in),
            .reset_n (reset_n),
            .wr      (wr_ok && (int'(wr_ch) == c)),
            .wr_div  (wr_div),
            .sync    (sync),
            .clk_out (clk_out[c]),
            .tick    (tick[c]),
            .pend    (pend[c])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with a short reset divisor (10) to keep runs brief.
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 4;
    localparam int DDIV   = 10;

    logic              clk_in = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic              sync_in;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    clk_div_bank #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DDIV),
        .CH_W    (CH_W)
    ) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
`ifdef CLKDIV_SYNC_EN
        .sync_in (sync_in),
`endif
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_wr(input logic en, input int ch, input int div);
        wr_en  = en;
        wr_ch  = CH_W'(ch);
        wr_div = CNT_W'(div);
    endtask

    // {sq, tk} d edges after a reference edge where the channel had sq=s0, tk=tk0, cnt=0.
    function automatic logic [1:0] ph(input int d, input int div, input logic s0, input logic tk0);
        logic tk_e;
        logic sq_e;
        tk_e = (d == 0) ? tk0 : ((d % div) == 0);
        sq_e = s0 ^ (((d / div) % 2) == 1);
        return {sq_e, tk_e};
    endfunction

    // Main scenario, edge e counted from reset release: {pend, sq, tk}.
    function automatic logic [2:0] exp_main(input int c, input int e);
        logic [1:0] st;
        logic       pd;
        st = ph(e, DDIV, 1'b0, 1'b0);
        pd = 1'b0;
        case (c)
            0: begin
                if (e >= 170) st = ph(e - 170, 4, 1'b1, 1'b1);
                pd = (e >= 160) && (e < 170);
            end
            1: begin
                if (e >= 50) st = ph(e - 50, 3, 1'b1, 1'b1);
                pd = (e >= 41) && (e < 50);
            end
            2: begin
                if (e >= 92)      st = ph(e - 92, 5, 1'b0, 1'b0);
                else if (e >= 81) st = 2'b00;
                pd = ((e >= 71) && (e < 80)) || (e == 91);
            end
            default: begin
                if (e >= 120) st = ph(e - 120, 1, 1'b0, 1'b1);
                pd = (e >= 111) && (e < 120);
            end
        endcase
        return {pd, st};
    endfunction

    // Sync scenario: ch0=4, ch1=6 written at edges 1/2, sync_in at edge 15.
    function automatic logic [2:0] exp_sync(input int c, input int e);
        logic [1:0] st;
        logic       pd;
        st = ph(e, DDIV, 1'b0, 1'b0);
        pd = 1'b0;
        if (c == 0) begin
            if (e >= 15)      st = ph(e - 15, 4, 1'b0, 1'b0);
            else if (e >= 10) st = ph(e - 10, 4, 1'b1, 1'b1);
            pd = (e >= 1) && (e < 10);
        end else if (c == 1) begin
            if (e >= 15)      st = ph(e - 15, 6, 1'b0, 1'b0);
            else if (e >= 10) st = ph(e - 10, 6, 1'b1, 1'b1);
            pd = (e >= 2) && (e < 10);
        end else if (e >= 15) begin
            st = ph(e - 15, DDIV, 1'b0, 1'b0);
        end
        return {pd, st};
    endfunction

    initial begin
        logic [NUM_CH-1:0] e_tk;
        logic [NUM_CH-1:0] e_sq;
        logic [NUM_CH-1:0] e_pd;
        logic [2:0]        v;

        reset_n = 1'b0;
        sync_in = 1'b0;
        set_wr(1'b0, 0, 0);

        chk("div_for_hz_480", 64'(div_for_hz(32'd480)), 64'd104167);
        chk("div_for_hz_1k", 64'(div_for_hz(32'd1000)), 64'd50000);

        repeat (3) step();
        chk("rst_clk_out", 64'(clk_out), 64'd0);
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_pend", 64'(pend), 64'd0);

        reset_n = 1'b1;
        for (int e = 1; e <= 172; e++) begin
            case (e)
                41:      set_wr(1'b1, 1, 3);
                71:      set_wr(1'b1, 2, 0);
                91:      set_wr(1'b1, 2, 5);
                111:     set_wr(1'b1, 3, 1);
                131:     set_wr(1'b1, 7, 77);
                160:     set_wr(1'b1, 0, 4);
                default: set_wr(1'b0, 0, 0);
            endcase
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                v       = exp_main(c, e);
                e_pd[c] = v[2];
                e_sq[c] = v[1];
                e_tk[c] = v[0];
            end
            chk($sformatf("tick@%0d", e), 64'(tick), 64'(e_tk));
            chk($sformatf("clk_out@%0d", e), 64'(clk_out), 64'(e_sq));
            chk($sformatf("pend@%0d", e), 64'(pend), 64'(e_pd));
        end
        set_wr(1'b0, 0, 0);

        // Mid-period reset (ch0 at cnt=2 of 4): outputs clear without an edge.
        reset_n = 1'b0;
        #1;
        chk("midrst_clk_out", 64'(clk_out), 64'd0);
        chk("midrst_tick", 64'(tick), 64'd0);
        chk("midrst_pend", 64'(pend), 64'd0);
        repeat (2) step();

`ifdef CLKDIV_SYNC_EN
        reset_n = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            case (e)
                1:       set_wr(1'b1, 0, 4);
                2:       set_wr(1'b1, 1, 6);
                default: set_wr(1'b0, 0, 0);
            endcase
            sync_in = (e == 15);
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                v       = exp_sync(c, e);
                e_pd[c] = v[2];
                e_sq[c] = v[1];
                e_tk[c] = v[0];
            end
            chk($sformatf("sync_tick@%0d", e), 64'(tick), 64'(e_tk));
            chk($sformatf("sync_clk_out@%0d", e), 64'(clk_out), 64'(e_sq));
            chk($sformatf("sync_pend@%0d", e), 64'(pend), 64'(e_pd));
        end
        sync_in = 1'b0;
        set_wr(1'b0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised, multi-channel successor to the single fixed-ratio display clock divider.
- Produces NUM_CH independent clocks from one system clock. Each channel has a runtime-programmable divisor.
- Each channel drives two outputs: a 50%-duty square output and a one-cycle tick enable.
- Feeds the seven-segment scan logic, the memory controllers and future peripherals, replacing per-use hard-coded dividers.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 32, width of divisor and counter per channel.
- DEF_DIV, 104167, divisor loaded into every channel at reset (100 MHz -> 480 Hz square).
- CH_W, 4, width of channel-select field; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk_in  input  1  system clock (100 MHz); all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  divisor write strobe, one cycle per write.
- wr_ch  input  CH_W  target channel of the write.
- wr_div  input  CNT_W  new divisor value; 0 disables the channel.
- clk_out  output  NUM_CH  per-channel square outputs, registered.
- tick  output  NUM_CH  per-channel single-cycle enables, registered.
- pend  output  NUM_CH  high while a written divisor is not yet in effect.

Behaviour:
- Per-channel state: cnt[CNT_W], div_act[CNT_W] (divisor in use), div_shd[CNT_W] (written divisor), sq, tk.
- Reset (reset_n low, asynchronous) sets:
  - cnt = 0, sq = 0, tk = 0;
  - div_act = div_shd = DEF_DIV;
  - therefore clk_out = 0, tick = 0, pend = 0.
- Write:
  - On a clock edge with wr_en = 1 and wr_ch < NUM_CH, div_shd[wr_ch] <= wr_div.
  - wr_ch >= NUM_CH is ignored; no state changes.
  - A second write before the first is applied overwrites div_shd; only the latest value is applied.
- pend[c] = (div_shd != div_act), combinational from registers.
- Running (div_act != 0), every edge:
  - If cnt == div_act - 1: cnt <= 0; tk <= 1; sq <= ~sq; div_act <= div_shd (new divisor applied only at wrap, so no runt half-period).
  - Else: cnt <= cnt + 1; tk <= 0.
- Resulting timing:
  - tick period = div_act cycles; tick high exactly 1 cycle.
  - clk_out period = 2*div_act cycles.
  - First tick after reset appears at edge DEF_DIV.
- div_act = 1: tick is constantly high and clk_out toggles every cycle (clk_in/2).
- Disabled (div_act == 0), every edge:
  - cnt <= 0, tk <= 0, sq <= 0;
  - div_act <= div_shd, so a nonzero write restarts the channel from phase 0 on the following edge.
- Writing 0 to a running channel takes effect at the next wrap. The wrap edge itself still produces its tick and toggle; on the next edge sq is forced 0.
- A write on the same edge as that channel's wrap:
  - the wrap loads the OLD div_shd into div_act;
  - the new value lands in div_shd and pend stays high until the next wrap.
- Counter arithmetic is unsigned CNT_W-bit. cnt never exceeds div_act - 1, so there is no overflow path.
- Channels are fully independent; writes to one never disturb another's phase.
- reset_n asserted mid-period clears everything immediately, with no waiting for wrap.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined:
  - Adds port sync_in (input, 1) after wr_div.
  - On an edge with sync_in = 1, every channel sets cnt <= 0, sq <= 0, tk <= 0 and div_act <= div_shd. This phase-aligns all channels and applies pending divisors at once.
  - sync_in has priority over the wrap and disable rules. A write on the same edge is captured into div_shd only and is applied at the next wrap.
- Not defined: port absent; behaviour exactly as above.

Decomposition:
- Package clk_div_pkg holds:
  - default CNT_W and DEF_DIV;
  - localparam SYS_CLK_HZ = 100_000_000;
  - a function computing the divisor from a target Hz as SYS_CLK_HZ/(2*hz), rounded.
- Sub-module clk_div_chan: one channel (counter, shadow/active divisor, sq, tk, pend).
- clk_div_bank holds:
  - the write decode;
  - optional sync fan-out;
  - a generate loop instantiating NUM_CH channels.

Test Plan:
- Reset with DEF_DIV=104167 -> clk_out = 0 and tick = 0 during reset; first tick[0] at edge 104167 after release; clk_out[0] period 208334 cycles, high 104167.
- NUM_CH=4, write ch1 = 3 -> pend[1] high until ch1's next wrap. After that: tick[1] every 3 cycles; clk_out[1] period 6; ch0, ch2 and ch3 timing unchanged.
- Write ch2 = 0, then ch2 = 5 twenty cycles later -> ch2 idles with clk_out[2] = 0; first tick 5 edges after div_act becomes 5.
- Write ch3 = 1 -> tick[3] constantly high and clk_out[3] toggles every cycle; write to wr_ch = 7 -> no register changes anywhere.
- Write coinciding with a wrap, and reset_n pulsed low mid-period at cnt = 2 of div = 4 -> old divisor applied at the wrap with pend still high; reset returns all outputs to 0 immediately.
- CLKDIV_SYNC_EN with ch0 = 4 and ch1 = 6 running out of phase, pulse sync_in -> both cnt = 0; ticks coincide at +4 and +6, then at +12.
